alu_op_sequencer: RTL

//   Control-side driver for the 8-bit ALU. Accepts 16-bit instructions over a valid/ready handshake.

---
 rtl/alu_op_sequencer.sv | 114 +++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - instruction sequencer driving an external 8-bit combinational ALU
//
// Purpose:
//   Accepts 16-bit instructions over a valid/ready handshake and reads operands
//   from a 4x8 register file. It drives the external ALU's sel/A/B inputs, then
//   writes the ALU result (or an immediate) back. It also implements the OUT
//   instruction and flags illegal opcodes.
//   Instruction format: [15:12] op, [11:10] rd, [9:8] rs, [7:6] rt, [7:0] imm8.
//   op 0..9 ALU ops, 10 LDI, 11 OUT, 12..15 illegal.
//
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   instr, instr_valid     instruction input and its valid flag
//   instr_ready            high while idle (can accept this cycle)
//   alu_sel, alu_a, alu_b  registered ALU controls: op, R[rs], R[rt]
//   alu_c                  ALU result, combinational from sel/a/b
//   out_data, out_valid    R[rs] of the last OUT instruction; one-cycle update pulse
//   illegal                one-cycle pulse for opcodes 12..15
//   dbg_addr, dbg_data     combinational read port on committed register state

module alu_op_sequencer #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [3:0]        alu_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_c,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              illegal,
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t            state;
  logic [DATA_W-1:0] rf [0:NREGS-1];
  logic [3:0]        op_q;
  logic [1:0]        rd_q;
  logic [DATA_W-1:0] imm_q;

  logic [3:0] f_op;
  logic [1:0] f_rd;
  logic [1:0] f_rs;
  logic [1:0] f_rt;

  assign f_op = instr[15:12];
  assign f_rd = instr[11:10];
  assign f_rs = instr[9:8];
  assign f_rt = instr[7:6];

  // Ready depends only on state, so the source never sees a combinational
  // path from instr_valid back to instr_ready.
  assign instr_ready = (state == IDLE);
  assign dbg_data    = rf[dbg_addr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      alu_sel   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        rf[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            op_q    <= f_op;
            rd_q    <= f_rd;
            imm_q   <= instr[DATA_W-1:0];
            // Operands are loaded for every opcode; non-ALU ops simply ignore alu_c.
            alu_sel <= f_op;
            alu_a   <= rf[f_rs];
            alu_b   <= rf[f_rt];
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (op_q <= 4'd9) begin
            rf[rd_q] <= alu_c;
          end else if (op_q == 4'd10) begin
            rf[rd_q] <= imm_q;
          end else if (op_q == 4'd11) begin
            // alu_a already holds R[rs] as read at acceptance.
            out_data  <= alu_a;
            out_valid <= 1'b1;
          end else begin
            illegal <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
